// File: rtl/btn_event_decoder.sv
// ---------------------------------------------------------------------------
// btn_event_decoder
//
// Turns one debounced button into clean one-cycle events for the
// watch/stopwatch control FSM: a single short press, a double press, a long
// press, and auto-repeat pulses while a long press keeps being held.
//
// Parameters
//   TICK_COUNT  clk cycles per 1 ms timer tick
//   LONG_MS     hold time (ms) before o_long fires
//   DOUBLE_MS   window (ms) after release in which a second press is a double
//   REPEAT_MS   o_repeat period (ms) while held after o_long
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous, active-high reset
//   i_btn        in   one-cycle press pulse (rising edge of debounced level)
//   i_btn_level  in   debounced button level, 1 = pressed
//   o_short      out  one-cycle pulse: single short press confirmed
//   o_double     out  one-cycle pulse: second press inside the double window
//   o_long       out  one-cycle pulse: press held LONG_MS
//   o_repeat     out  one-cycle pulse every REPEAT_MS while held
//   o_held       out  level: 1 while in the HELD state
// ---------------------------------------------------------------------------
module btn_event_decoder #(
    parameter int TICK_COUNT = 100000,
    parameter int LONG_MS    = 1000,
    parameter int DOUBLE_MS  = 300,
    parameter int REPEAT_MS  = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    input  logic i_btn_level,
    output logic o_short,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    // ------------------------------------------------------------------
    // Timer sizing: the ms counter only has to reach the largest of the
    // three timeouts; one spare bit keeps the saturation point clear of it.
    // ------------------------------------------------------------------
    localparam int MS_MAX_A = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
    localparam int MS_MAX   = (MS_MAX_A > REPEAT_MS) ? MS_MAX_A : REPEAT_MS;
    localparam int PS_W     = $clog2(TICK_COUNT) + 1;
    localparam int MS_W     = $clog2(MS_MAX) + 1;

    localparam logic [PS_W-1:0] PS_LAST     = PS_W'(TICK_COUNT - 1);
    localparam logic [MS_W-1:0] LONG_LAST   = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0] DOUBLE_LAST = MS_W'(DOUBLE_MS - 1);
    localparam logic [MS_W-1:0] REPEAT_LAST = MS_W'(REPEAT_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        HELD,
        WAIT2,
        PRESS2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [PS_W-1:0] prescaler;
    logic [MS_W-1:0] ms_cnt;
    logic            ms_tick;

    logic            timeout;
    logic            timer_clr;
    logic            short_next;
    logic            double_next;
    logic            long_next;
    logic            repeat_next;

    assign ms_tick = (prescaler == PS_LAST);

    // ------------------------------------------------------------------
    // Next-state and event decode. Within each state the checks are
    // written in priority order: release / new press always beats a
    // timeout that lands on the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        timeout     = 1'b0;
        short_next  = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;

        case (state)
            IDLE: begin
                // Only the press pulse starts a sequence; a level that is
                // already high (e.g. held through reset) is ignored.
                if (i_btn) begin
                    state_next = PRESSED;
                end
            end

            PRESSED: begin
                if (!i_btn_level) begin
                    state_next = WAIT2;
                end else if (ms_tick && (ms_cnt == LONG_LAST)) begin
                    state_next = HELD;
                    long_next  = 1'b1;
                end
            end

            HELD: begin
                if (!i_btn_level) begin
                    state_next = IDLE;
                end else if (ms_tick && (ms_cnt == REPEAT_LAST)) begin
                    // Staying in HELD, so the timer restart has to be
                    // requested explicitly rather than via a state change.
                    repeat_next = 1'b1;
                    timeout     = 1'b1;
                end
            end

            WAIT2: begin
                if (i_btn) begin
                    state_next  = PRESS2;
                    double_next = 1'b1;
                end else if (ms_tick && (ms_cnt == DOUBLE_LAST)) begin
                    state_next = IDLE;
                    short_next = 1'b1;
                end
            end

            PRESS2: begin
                // Second press of a double: no long detection, just wait
                // for the release however long that takes.
                if (!i_btn_level) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        timer_clr = timeout || (state_next != state);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Millisecond timer. The prescaler wraps every tick; ms_cnt saturates
    // so that long stays in IDLE or PRESS2 can never wrap it back into
    // a timeout value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || timer_clr) begin
            prescaler <= '0;
            ms_cnt    <= '0;
        end else begin
            if (ms_tick) begin
                prescaler <= '0;
                if (ms_cnt != '1) begin
                    ms_cnt <= ms_cnt + MS_W'(1);
                end
            end else begin
                prescaler <= prescaler + PS_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. o_held follows the next state so it rises on
    // the same cycle as o_long and drops as soon as HELD is left.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            o_short  <= 1'b0;
            o_double <= 1'b0;
            o_long   <= 1'b0;
            o_repeat <= 1'b0;
            o_held   <= 1'b0;
        end else begin
            o_short  <= short_next;
            o_double <= double_next;
            o_long   <= long_next;
            o_repeat <= repeat_next;
            o_held   <= (state_next == HELD);
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_btn_event_decoder
//
// Self-checking bench for btn_event_decoder with small timing parameters
// (TICK_COUNT=4, LONG_MS=10, DOUBLE_MS=5, REPEAT_MS=3). Every cycle the DUT
// outputs are compared with a reference model that tracks elapsed cycles in
// the current phase; a table of press scenarios additionally checks event
// counts and the step at which the first event appears.
// ---------------------------------------------------------------------------
module tb_btn_event_decoder;

    localparam int T   = 4;
    localparam int LMS = 10;
    localparam int DMS = 5;
    localparam int RMS = 3;

    logic clk = 1'b0;
    logic rst;
    logic i_btn;
    logic i_btn_level;
    logic o_short, o_double, o_long, o_repeat, o_held;

    btn_event_decoder #(
        .TICK_COUNT(T),
        .LONG_MS   (LMS),
        .DOUBLE_MS (DMS),
        .REPEAT_MS (RMS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_btn      (i_btn),
        .i_btn_level(i_btn_level),
        .o_short    (o_short),
        .o_double   (o_double),
        .o_long     (o_long),
        .o_repeat   (o_repeat),
        .o_held     (o_held)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase of the press sequence plus cycles spent in it.
    localparam int PH_IDLE  = 0;
    localparam int PH_DOWN  = 1;
    localparam int PH_HOLD  = 2;
    localparam int PH_GAP   = 3;
    localparam int PH_DOWN2 = 4;

    int       m_phase = PH_IDLE;
    int       m_elap  = 0;
    bit [4:0] m_exp   = '0;  // {short, double, long, repeat, held}

    // Scenario bookkeeping (counted from DUT outputs)
    int seq_step, n_short, n_double, n_long, n_repeat, first_evt;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_edge(input bit r, input bit b, input bit l);
        bit es, ed, el, er, to;
        int nph;
        es = 0; ed = 0; el = 0; er = 0; to = 0;
        nph = m_phase;
        if (r) begin
            m_phase = PH_IDLE;
            m_elap  = 0;
            m_exp   = '0;
            return;
        end
        case (m_phase)
            PH_IDLE:  if (b) nph = PH_DOWN;
            PH_DOWN:  if (!l) nph = PH_GAP;
                      else if (m_elap == LMS * T - 1) begin nph = PH_HOLD; el = 1; end
            PH_HOLD:  if (!l) nph = PH_IDLE;
                      else if (m_elap == RMS * T - 1) begin er = 1; to = 1; end
            PH_GAP:   if (b) begin nph = PH_DOWN2; ed = 1; end
                      else if (m_elap == DMS * T - 1) begin nph = PH_IDLE; es = 1; end
            PH_DOWN2: if (!l) nph = PH_IDLE;
            default:  nph = PH_IDLE;
        endcase
        if (nph != m_phase || to) m_elap = 0;
        else m_elap++;
        m_phase = nph;
        m_exp = {es, ed, el, er, (nph == PH_HOLD)};
    endtask

    // One clock: drive inputs, advance past the edge, update model, compare.
    task automatic step(input bit r, input bit b, input bit l);
        bit [4:0] got;
        rst = r; i_btn = b; i_btn_level = l;
        seq_step++;
        @(posedge clk);
        #1;
        model_edge(r, b, l);
        got = {o_short, o_double, o_long, o_repeat, o_held};
        check($sformatf("cycle t=%0t outs(s,d,l,r,h)", $time), int'(got), int'(m_exp));
        if (o_short)  n_short++;
        if (o_double) n_double++;
        if (o_long)   n_long++;
        if (o_repeat) n_repeat++;
        if ((o_short || o_double || o_long || o_repeat) && first_evt == 0)
            first_evt = seq_step;
    endtask

    task automatic clear_counts();
        seq_step = 0; n_short = 0; n_double = 0; n_long = 0; n_repeat = 0; first_evt = 0;
    endtask

    typedef struct {
        string name;
        int press_len;  // cycles with level high, press pulse on the first
        int gap;        // released cycles after the first press
        int has2;       // a second press follows the gap
        int len2;       // level-high cycles of the second press
        int tail;       // released cycles at the end
        int e_short, e_double, e_long, e_repeat;
        int e_first;    // step of the first event (step 1 = press pulse)
    } scn_t;

    scn_t scn[6];

    task automatic run_scn(input scn_t s);
        clear_counts();
        for (int i = 1; i <= s.press_len; i++) step(0, i == 1, 1);
        for (int i = 0; i < s.gap; i++) step(0, 0, 0);
        if (s.has2 != 0)
            for (int i = 1; i <= s.len2; i++) step(0, i == 1, 1);
        for (int i = 0; i < s.tail; i++) step(0, 0, 0);
        check({s.name, " short"},  n_short,   s.e_short);
        check({s.name, " double"}, n_double,  s.e_double);
        check({s.name, " long"},   n_long,    s.e_long);
        check({s.name, " repeat"}, n_repeat,  s.e_repeat);
        check({s.name, " first"},  first_evt, s.e_first);
    endtask

    initial begin
        int lvl, run;

        scn[0] = '{"short",        8, 30, 0, 0, 0,  1, 0, 0, 0, 29};
        scn[1] = '{"double",       8,  6, 1, 5, 10, 0, 1, 0, 0, 15};
        scn[2] = '{"long_repeat", 100, 30, 0, 0, 0, 0, 0, 1, 4, 41};
        scn[3] = '{"rel_on_long", 40, 30, 0, 0, 0,  1, 0, 0, 0, 61};
        scn[4] = '{"dbl_on_to",    8, 20, 1, 4, 10, 0, 1, 0, 0, 29};
        scn[5] = '{"tap",          1, 25, 0, 0, 0,  1, 0, 0, 0, 22};

        rst = 1'b1; i_btn = 1'b0; i_btn_level = 1'b1;
        clear_counts();

        // Reset with the level high, then the level alone must not start a press.
        step(1, 0, 1);
        step(1, 0, 1);
        check("reset outs", int'({o_short, o_double, o_long, o_repeat, o_held}), 0);
        for (int i = 0; i < 12; i++) step(0, 0, 1);
        check("level only idle held", int'(o_held), 0);
        step(0, 0, 0);

        foreach (scn[k]) run_scn(scn[k]);

        // Reset mid-HELD landing on a repeat edge: nothing may fire.
        clear_counts();
        for (int i = 1; i <= 52; i++) step(0, i == 1, 1);
        check("pre-reset held", int'(o_held), 1);
        step(1, 0, 1);
        check("reset in held outs", int'({o_short, o_double, o_long, o_repeat, o_held}), 0);
        check("reset in held repeat cnt", n_repeat, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        run_scn(scn[0]);

        // Randomised debounced-level stream; press pulse on each rising edge.
        clear_counts();
        lvl = 0;
        for (int n = 0; n < 120; n++) begin
            lvl = 1 - lvl;
            run = (($urandom % 4) == 0) ? $urandom_range(35, 60) : $urandom_range(1, 30);
            for (int i = 0; i < run; i++) begin
                if (($urandom % 600) == 0) step(1, 0, lvl[0]);
                else step(0, (lvl == 1) && (i == 0), lvl[0]);
            end
        end
        for (int i = 0; i < 30; i++) step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
